// File: rtl/cache_control.sv
// cache_control: sequencing FSM for the 2-way, 8-set write-back cache.
// Decodes CPU requests against datapath hit/dirty/LRU status, drives all
// array loads and mux selects, and runs pmem writeback/allocate handshakes.
// Optional macro CACHE_PERF_CNT_EN adds saturating hit/miss/writeback counters.
module cache_control #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
`ifdef CACHE_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] writeback_count,
`endif
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,
  input  logic       pmem_resp,
  output logic       pmem_read,
  output logic       pmem_write,
  input  logic       ishit_w1,
  input  logic       ishit_w2,
  input  logic       isdirty_w1,
  input  logic       isdirty_w2,
  input  logic       lru_out,
  output logic       load_dirty_w1,
  output logic       load_valid_w1,
  output logic       load_tag_w1,
  output logic       load_datastore_w1,
  output logic       load_dirty_w2,
  output logic       load_valid_w2,
  output logic       load_tag_w2,
  output logic       load_datastore_w2,
  output logic       dirty_array_w1_in,
  output logic       dirty_array_w2_in,
  output logic       datastore_in_mux_sel,
  output logic [1:0] pmem_address_mux_sel,
  output logic       load_lru,
  output logic       lru_in
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   req;
  logic   hit;

  assign req = mem_read | mem_write;
  assign hit = ishit_w1 | ishit_w2;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath control; the victim way is always lru_out
  always_comb begin
    state_d              = state_q;
    mem_resp             = 1'b0;
    pmem_read            = 1'b0;
    pmem_write           = 1'b0;
    load_dirty_w1        = 1'b0;
    load_valid_w1        = 1'b0;
    load_tag_w1          = 1'b0;
    load_datastore_w1    = 1'b0;
    load_dirty_w2        = 1'b0;
    load_valid_w2        = 1'b0;
    load_tag_w2          = 1'b0;
    load_datastore_w2    = 1'b0;
    dirty_array_w1_in    = 1'b0;
    dirty_array_w2_in    = 1'b0;
    datastore_in_mux_sel = 1'b0;
    pmem_address_mux_sel = 2'b10;
    load_lru             = 1'b0;
    lru_in               = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            load_lru = 1'b1;
            lru_in   = ishit_w1;
            if (mem_write) begin
              datastore_in_mux_sel = 1'b1;
              if (ishit_w1) begin
                load_datastore_w1 = 1'b1;
                load_dirty_w1     = 1'b1;
                dirty_array_w1_in = 1'b1;
              end else begin
                load_datastore_w2 = 1'b1;
                load_dirty_w2     = 1'b1;
                dirty_array_w2_in = 1'b1;
              end
            end
          end else if (lru_out ? isdirty_w2 : isdirty_w1) begin
            state_d = WRITEBACK;
          end else begin
            state_d = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write           = 1'b1;
        pmem_address_mux_sel = {1'b0, lru_out};
        if (pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          if (lru_out) begin
            load_datastore_w2 = 1'b1;
            load_tag_w2       = 1'b1;
            load_valid_w2     = 1'b1;
            load_dirty_w2     = 1'b1;
          end else begin
            load_datastore_w1 = 1'b1;
            load_tag_w1       = 1'b1;
            load_valid_w1     = 1'b1;
            load_dirty_w1     = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] hit_q, hit_d, miss_q, miss_d, wb_q, wb_d;
  logic                 miss_pending_q, miss_pending_d;

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q          <= '0;
      miss_q         <= '0;
      wb_q           <= '0;
      miss_pending_q <= 1'b0;
    end else begin
      hit_q          <= hit_d;
      miss_q         <= miss_d;
      wb_q           <= wb_d;
      miss_pending_q <= miss_pending_d;
    end
  end

  // Saturating event counting; the retried hit after a fill is not a new hit
  always_comb begin
    hit_d          = hit_q;
    miss_d         = miss_q;
    wb_d           = wb_q;
    miss_pending_d = miss_pending_q;
    if (state_q == IDLE && state_d != IDLE) begin
      if (miss_q != '1) miss_d = miss_q + 1'b1;
      miss_pending_d = 1'b1;
    end
    if (mem_resp) begin
      if (!miss_pending_q && hit_q != '1) hit_d = hit_q + 1'b1;
      miss_pending_d = 1'b0;
    end
    if (state_q == ALLOCATE && pmem_resp && !req) miss_pending_d = 1'b0;
    if (state_q == WRITEBACK && pmem_resp && wb_q != '1) wb_d = wb_q + 1'b1;
  end

  assign hit_count       = hit_q;
  assign miss_count      = miss_q;
  assign writeback_count = wb_q;
`else
  logic unused_cnt_width;
  assign unused_cnt_width = (CNT_WIDTH == 0);
`endif

endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
- Sequencing FSM for the 2-way, 8-set, 16-byte-line write-back cache datapath.
- Decodes CPU mem_read/mem_write against the hit, dirty and LRU status from the datapath.
- Drives all datapath array loads and mux selects, and runs the physical-memory writeback/allocate handshakes.
- Sits between the CPU memory port, cache_datapath and physical memory.

Parameters:
CNT_WIDTH, 16, width of the performance counters; used only when CACHE_PERF_CNT_EN is defined.

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_resp  out  1  one-cycle CPU completion pulse
pmem_resp  in  1  physical memory completion pulse
pmem_read  out  1  physical memory line read request
pmem_write  out  1  physical memory line write request
ishit_w1, ishit_w2  in  1 each  way hit (tag match and valid)
isdirty_w1, isdirty_w2  in  1 each  way valid and dirty at the current set
lru_out  in  1  LRU bit of the current set; 0 = way 1 is victim, 1 = way 2 is victim
load_dirty_w1, load_valid_w1, load_tag_w1, load_datastore_w1  out  1 each  way 1 array write enables
load_dirty_w2, load_valid_w2, load_tag_w2, load_datastore_w2  out  1 each  way 2 array write enables
dirty_array_w1_in, dirty_array_w2_in  out  1 each  dirty bit to write
datastore_in_mux_sel  out  1  0 = pmem_rdata (fill), 1 = merged CPU write data
pmem_address_mux_sel  out  2  00 = way 1 line address, 01 = way 2 line address, 10 = CPU address
load_lru  out  1  LRU array write enable
lru_in  out  1  LRU value to write

Behaviour:
- States: IDLE, WRITEBACK, ALLOCATE. Moore/Mealy mix; datapath arrays read combinationally, so hit status is valid in the same cycle.
- Default outputs (every cycle unless a rule below overrides): all 0, except pmem_address_mux_sel = 10.
- Reset: state goes to IDLE and all outputs take their defaults on the next edge. An active pmem_read/pmem_write drops immediately; pmem must tolerate an abandoned request. Arrays are not reset.
- Request decode: req = mem_read | mem_write. If both are asserted, treat as a write.

IDLE, req and hit (ishit_w1 | ishit_w2):
- Combinational mem_resp = 1 in the same cycle.
- load_lru = 1; lru_in = ishit_w1, so the other way becomes LRU.
- If both hit bits are set (illegal), way 1 wins.
- On a write: datastore_in_mux_sel = 1, load_datastore_wX = 1, load_dirty_wX = 1, dirty_array_wX_in = 1 for the hit way.
- Stay in IDLE. Zero-wait hit latency.

IDLE, req and miss:
- Victim = lru_out.
- If the victim's isdirty is set, go to WRITEBACK; otherwise go to ALLOCATE.
- No mem_resp.

WRITEBACK:
- pmem_write = 1; pmem_address_mux_sel = {0, lru_out}.
- Hold until pmem_resp, then go to ALLOCATE.
- Always completes, even if the CPU drops its request.

ALLOCATE:
- pmem_read = 1; pmem_address_mux_sel = 10.
- On the pmem_resp cycle, for the victim way only: load_datastore, load_tag, load_valid and load_dirty = 1, with dirty_in = 0 and datastore_in_mux_sel = 0.
- Then go to IDLE. The retried access hits the following cycle, so miss latency is pmem latency plus 1.
- Always completes.

Other rules:
- lru_out must not change during a miss, because no LRU write occurs in WRITEBACK or ALLOCATE.
- No array writes occur in any cycle without the stated conditions.
- If the request is withdrawn after a miss, the line is still filled and the FSM returns to IDLE with no mem_resp.

Optional Feature:
- Macro: CACHE_PERF_CNT_EN.
- When defined, adds outputs hit_count, miss_count and writeback_count, each [CNT_WIDTH-1:0].
- Counters are saturating, reset to 0 by rst, and advance as follows:
  - miss_count +1 on each IDLE-to-WRITEBACK/ALLOCATE transition; this also sets an internal miss_pending flag.
  - hit_count +1 on each mem_resp pulse where miss_pending = 0. miss_pending clears on mem_resp or on the return to IDLE with the request withdrawn.
  - writeback_count +1 on each pmem_resp in WRITEBACK.
- When undefined, the ports, counters and flag are absent and the remaining behaviour is identical.

Test Plan:
1. Clean read miss:
   - Stimulus: after reset, mem_read=1, misses in both ways, lru_out=0, isdirty_w1=0; pmem_resp arrives 5 cycles later.
   - Response: ALLOCATE with pmem_read=1 and sel=10. On the pmem_resp cycle, load_datastore_w1 = load_tag_w1 = load_valid_w1 = load_dirty_w1 = 1, dirty_array_w1_in = 0, datastore_in_mux_sel = 0.
   - Next cycle: ishit_w1=1 gives mem_resp=1, load_lru=1, lru_in=1.
2. Write hit on way 2:
   - Stimulus: mem_write=1, ishit_w2=1.
   - Response, same cycle: mem_resp=1, load_datastore_w2=1, datastore_in_mux_sel=1, load_dirty_w2=1, dirty_array_w2_in=1, lru_in=0.
   - Way 1 enables stay 0.
3. Dirty miss:
   - Stimulus: mem_read=1, miss, lru_out=1, isdirty_w2=1; pmem_resp after 3 cycles.
   - Response: pmem_write=1 and sel=01 for exactly those 3 cycles plus the resp cycle, then ALLOCATE with pmem_read=1 and sel=10.
4. Reset mid-operation:
   - Stimulus: rst=1 for 1 cycle during ALLOCATE, before pmem_resp.
   - Response: next cycle pmem_read=0, state IDLE, all load_* = 0, mem_resp=0.
5. Withdrawn request:
   - Stimulus: mem_read drops during WRITEBACK.
   - Response: WRITEBACK and ALLOCATE both complete, no mem_resp is issued, the FSM returns to IDLE, and the victim way's arrays are loaded.
6. Counters, with CACHE_PERF_CNT_EN:
   - 3 hits, 1 clean miss, 1 dirty miss gives hit_count=3, miss_count=2, writeback_count=1.
   - With CNT_WIDTH=2, 5 hits give hit_count=3 (saturated).
